// File: rtl/nv_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
`timescale 1ns/1ps
package nv_fifo_pkg;

  // Number of entries held in the output skid buffer.
  localparam int SKID_DEPTH = 32'sd2;

  // Smallest address width able to index 'depth' entries.
  function automatic int calc_aw(input int depth);
    int aw;
    aw = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < depth) begin
        aw = i + 32'sd1;
      end else begin
        aw = aw;
      end
    end
    return aw;
  endfunction

endpackage

// File: rtl/nv_fifo_chk.sv
// Invariant checker for the FIFO controller counters and write safety.
`timescale 1ns/1ps
module nv_fifo_chk #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input logic          clk,
  input logic          rst_n,
  input logic [AW:0]   ram_cnt,
  input logic [1:0]    skid_cnt,
  input logic          inflight,
  input logic          ram_we,
  input logic [AW-1:0] ram_wa,
  input logic [AW-1:0] rd_ptr
);

  logic [AW-1:0] free_wa_s;

  // The only free slot following the occupied region starts at the oldest
  // uncaptured entry (rd_ptr minus any in-flight read) plus ram_cnt.
  always_comb begin
    free_wa_s = rd_ptr - {{(AW-1){1'b0}}, inflight} + ram_cnt[AW-1:0];
  end

  a_ram_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ram_cnt <= (AW+1)'(DEPTH));

  a_skid_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, skid_cnt} + {2'b00, inflight}) <= 3'd2);

  a_we_safe: assert property (@(posedge clk) disable iff (!rst_n)
    ram_we |-> ((ram_cnt < (AW+1)'(DEPTH)) && (ram_wa == free_wa_s)));

endmodule

// File: rtl/nv_fifo_skid2.sv
// Two-entry skid buffer: entries are captured from RAM read data and
// presented on a registered valid/ready pop interface (head register).
`timescale 1ns/1ps
module nv_fifo_skid2
  import nv_fifo_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_vld,
  input  logic [DW-1:0] cap_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic [1:0]    cnt
);

  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          vld_q, vld_d;
  logic          pop_s;

  // Next-state of the two slots; the head only moves on a pop or when an
  // empty buffer captures, so out_data is stable while stalled or empty.
  always_comb begin
    pop_s  = vld_q & out_rdy;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({cap_vld, pop_s})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          head_d = cap_data;
        end else begin
          tail_d = cap_data;
        end
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = cap_data;
        end else begin
          head_d = tail_q;
          tail_d = cap_data;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    vld_d = (cnt_d != 2'd0);
  end

  // Skid state registers, cleared to zero so the pop data is X-safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= {DW{1'b0}};
      tail_q <= {DW{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = head_q;
  assign cnt      = cnt_q;

endmodule

// File: rtl/nv_ram_rws_fifo_ctrl.sv
// Valid/ready FIFO controller in front of an external 1R1W RAM with a
// registered read address. Reads are issued ahead of demand into a
// 2-entry skid buffer so a steady stream moves one entry per cycle.
`timescale 1ns/1ps
module nv_ram_rws_fifo_ctrl
  import nv_fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = calc_aw(DEPTH),
  parameter int DW    = 512
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_pd,
  output logic          fifo_idle
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          inflight_q, inflight_d;
  logic          wr_prdy_q, wr_prdy_d;

  logic          push_s;
  logic          pop_s;
  logic          cap_s;
  logic          issue_s;
  logic [2:0]    occ_s;
  logic [2:0]    room_s;
  logic [1:0]    skid_cnt_s;
  logic          rd_pvld_s;

  // Pointer/counter next state. A RAM slot is released only at capture, so
  // ram_cnt covers the in-flight read and no pending slot is ever rewritten.
  // A pop in the current cycle counts as a freed skid slot for read issue.
  always_comb begin
    push_s    = wr_pvld & wr_prdy_q;
    pop_s     = rd_pvld_s & rd_prdy;
    cap_s     = inflight_q;
    occ_s     = {1'b0, skid_cnt_s} + {2'b00, inflight_q};
    room_s    = 3'd2 + {2'b00, pop_s};
    issue_s   = (ram_cnt_q > {{AW{1'b0}}, inflight_q}) && (occ_s < room_s);
    ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, cap_s};
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    inflight_d = issue_s;
    wr_prdy_d  = (ram_cnt_d < (AW+1)'(DEPTH));
  end

  // Controller state registers; wr_prdy stays low through reset.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      ram_cnt_q  <= {(AW+1){1'b0}};
      inflight_q <= 1'b0;
      wr_prdy_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      wr_prdy_q  <= wr_prdy_d;
    end
  end

  nv_fifo_skid2 #(
    .DW (DW)
  ) u_skid (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .cap_vld  (cap_s),
    .cap_data (ram_dout),
    .out_vld  (rd_pvld_s),
    .out_rdy  (rd_prdy),
    .out_data (rd_pd),
    .cnt      (skid_cnt_s)
  );

  nv_fifo_chk #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_chk (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .ram_cnt  (ram_cnt_q),
    .skid_cnt (skid_cnt_s),
    .inflight (inflight_q),
    .ram_we   (push_s),
    .ram_wa   (wr_ptr_q),
    .rd_ptr   (rd_ptr_q)
  );

  assign wr_prdy       = wr_prdy_q;
  assign rd_pvld       = rd_pvld_s;
  assign ram_we        = push_s;
  assign ram_wa        = wr_ptr_q;
  assign ram_di        = wr_pd;
  assign ram_re        = issue_s;
  assign ram_ra        = rd_ptr_q;
  assign ram_pwrbus_pd = pwrbus_ram_pd;
  assign fifo_idle     = (ram_cnt_q == {(AW+1){1'b0}}) & (skid_cnt_s == 2'd0) & ~wr_pvld;

endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl.sv
// Directed bench for nv_ram_rws_fifo_ctrl with a behavioural 1R1W RAM.
`timescale 1ns/1ps
module tb_nv_ram_rws_fifo_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 512;

  logic          clk;
  logic          rstn;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic [31:0]   pwrbus_ram_pd;
  logic [31:0]   ram_pwrbus_pd;
  logic          fifo_idle;

  int n_tests;
  int n_fail;

  nv_ram_rws_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_dout        (ram_dout),
    .pwrbus_ram_pd   (pwrbus_ram_pd),
    .ram_pwrbus_pd   (ram_pwrbus_pd),
    .fifo_idle       (fifo_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, read address registered on ram_re.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_lat;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_lat <= ram_ra;
  end
  assign ram_dout = mem[ra_lat];

  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return {(DW/32){v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0; pwrbus_ram_pd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    wr_pvld = 1'b1;
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_held: got %0b want 0", ram_we); end
    n_tests++; if (fifo_idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle_wrpvld: got %0b want 0", fifo_idle); end
    wr_pvld = 1'b0;
    #1;
    n_tests++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL reset_wr_prdy: got %0b want 0", wr_prdy); end
    n_tests++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pvld: got %0b want 0", rd_pvld); end
    n_tests++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_ram_re: got %0b want 0", ram_re); end
    n_tests++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", fifo_idle); end
    n_tests++; if (rd_pd !== {DW{1'b0}}) begin n_fail++; $display("FAIL reset_rd_pd: got %h want 0", rd_pd); end
    rstn = 1'b1;
    tick();
    #2;
    n_tests++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL release_wr_prdy: got %0b want 1", wr_prdy); end
    n_tests++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL release_rd_pvld: got %0b want 0", rd_pvld); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = mk(32'hA5A5A5A5);
    wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
    #1;
    n_tests++; if (ram_we !== 1'b1 || ram_wa !== 6'd0) begin n_fail++; $display("FAIL single_we: we=%0b wa=%0d want we=1 wa=0", ram_we, ram_wa); end
    n_tests++; if (ram_di !== d) begin n_fail++; $display("FAIL single_di: got %h want %h", ram_di, d); end
    n_tests++; if (fifo_idle !== 1'b0) begin n_fail++; $display("FAIL single_idle0: got %0b want 0", fifo_idle); end
    tick();
    wr_pvld = 1'b0;
    #2;
    n_tests++; if (ram_re !== 1'b1 || ram_ra !== 6'd0) begin n_fail++; $display("FAIL single_re: re=%0b ra=%0d want re=1 ra=0", ram_re, ram_ra); end
    n_tests++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL single_pvld_c1: got %0b want 0", rd_pvld); end
    tick();
    #2;
    n_tests++; if (ram_re !== 1'b0 || rd_pvld !== 1'b0) begin n_fail++; $display("FAIL single_c2: re=%0b pvld=%0b want 0 0", ram_re, rd_pvld); end
    tick();
    #2;
    n_tests++; if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL single_pvld_c3: got %0b want 1", rd_pvld); end
    n_tests++; if (rd_pd !== d) begin n_fail++; $display("FAIL single_pd: got %h want %h", rd_pd, d); end
    tick();
    #2;
    n_tests++; if (rd_pvld !== 1'b0 || fifo_idle !== 1'b1) begin n_fail++; $display("FAIL single_drained: pvld=%0b idle=%0b want 0 1", rd_pvld, fifo_idle); end
  endtask

  task automatic test_fill();
    int acc;
    int n;
    acc = 0; n = 0;
    rd_prdy = 1'b0;
    for (int c = 0; c < 70; c++) begin
      wr_pvld = 1'b1; wr_pd = mk(acc);
      #2;
      if (c >= 66) begin
        n_tests++; if (wr_prdy !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL fill_full_c%0d: prdy=%0b we=%0b want 0 0", c, wr_prdy, ram_we); end
      end
      if (wr_prdy) acc++;
      tick();
    end
    n_tests++; if (acc !== 66) begin n_fail++; $display("FAIL fill_accepted: got %0d want 66", acc); end
    n_tests++; if (rd_pvld !== 1'b1 || rd_pd !== mk(32'd0)) begin n_fail++; $display("FAIL fill_head: pvld=%0b pd=%h want 1 %h", rd_pvld, rd_pd, mk(32'd0)); end
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    for (int cyc = 0; cyc < 200 && n < 66; cyc++) begin
      #2;
      if (cyc == 0 || cyc == 1) begin
        n_tests++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL drain_prdy_c%0d: got %0b want 0", cyc, wr_prdy); end
      end
      if (cyc == 2) begin
        n_tests++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL drain_prdy_reassert: got %0b want 1", wr_prdy); end
      end
      if (rd_pvld && rd_prdy) begin
        n_tests++; if (rd_pd !== mk(n)) begin n_fail++; $display("FAIL drain_data_%0d: got %h want %h", n, rd_pd, mk(n)); end
        n++;
      end
      tick();
    end
    n_tests++; if (n !== 66) begin n_fail++; $display("FAIL drain_count: got %0d want 66", n); end
    #2;
    n_tests++; if (rd_pvld !== 1'b0 || fifo_idle !== 1'b1) begin n_fail++; $display("FAIL drain_empty: pvld=%0b idle=%0b want 0 1", rd_pvld, fifo_idle); end
  endtask

  task automatic test_stream();
    int p;
    int n;
    int first;
    int bubbles;
    p = 0; n = 0; first = -1; bubbles = 0;
    rd_prdy = 1'b1;
    for (int cyc = 0; cyc < 400 && n < 200; cyc++) begin
      wr_pvld = (p < 200); wr_pd = mk(32'h1000 + p);
      #2;
      if (wr_pvld) begin
        n_tests++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL stream_prdy_c%0d: got %0b want 1", cyc, wr_prdy); end
        if (wr_prdy) p++;
      end
      if (rd_pvld) begin
        n_tests++; if (rd_pd !== mk(32'h1000 + n)) begin n_fail++; $display("FAIL stream_data_%0d: got %h want %h", n, rd_pd, mk(32'h1000 + n)); end
        n++;
        if (first < 0) first = cyc;
      end else if (first >= 0) begin
        bubbles++;
      end
      tick();
    end
    wr_pvld = 1'b0;
    n_tests++; if (n !== 200) begin n_fail++; $display("FAIL stream_count: got %0d want 200", n); end
    n_tests++; if (first !== 3) begin n_fail++; $display("FAIL stream_latency: got %0d want 3", first); end
    n_tests++; if (bubbles !== 0) begin n_fail++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
  endtask

  task automatic test_backpressure();
    int p;
    int n;
    logic stall_prev;
    logic [DW-1:0] prev_pd;
    p = 0; n = 0; stall_prev = 1'b0; prev_pd = '0;
    for (int cyc = 0; cyc < 20000 && n < 1000; cyc++) begin
      wr_pvld = (p < 1000) && ($urandom_range(99) < 70);
      wr_pd = mk(32'h20000 + p);
      rd_prdy = ($urandom_range(99) < 30);
      #2;
      if (stall_prev) begin
        n_tests++; if (rd_pvld !== 1'b1 || rd_pd !== prev_pd) begin n_fail++; $display("FAIL bp_stable_c%0d: pvld=%0b pd=%h want 1 %h", cyc, rd_pvld, rd_pd, prev_pd); end
      end
      if (wr_pvld && wr_prdy) p++;
      if (rd_pvld && rd_prdy) begin
        n_tests++; if (rd_pd !== mk(32'h20000 + n)) begin n_fail++; $display("FAIL bp_data_%0d: got %h want %h", n, rd_pd, mk(32'h20000 + n)); end
        n++;
      end
      stall_prev = rd_pvld && !rd_prdy;
      prev_pd = rd_pd;
      tick();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    n_tests++; if (n !== 1000) begin n_fail++; $display("FAIL bp_count: got %0d want 1000", n); end
    #2;
    n_tests++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %0b want 1", fifo_idle); end
  endtask

  task automatic test_midreset();
    logic [DW-1:0] d;
    int lat;
    d = mk(32'h3C3C3C3C);
    rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1; wr_pd = mk(32'h300 + i);
      tick();
    end
    wr_pvld = 1'b0;
    tick(); tick();
    #2;
    n_tests++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL mr_skid_full_no_re: got %0b want 0", ram_re); end
    rd_prdy = 1'b1;
    #1;
    n_tests++; if (ram_re !== 1'b1) begin n_fail++; $display("FAIL mr_release_re: got %0b want 1", ram_re); end
    tick();
    rd_prdy = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    n_tests++; if (rd_pvld !== 1'b0 || wr_prdy !== 1'b0 || ram_re !== 1'b0) begin n_fail++; $display("FAIL mr_async: pvld=%0b prdy=%0b re=%0b want 0 0 0", rd_pvld, wr_prdy, ram_re); end
    n_tests++; if (rd_pd !== {DW{1'b0}} || fifo_idle !== 1'b1) begin n_fail++; $display("FAIL mr_cleared: pd=%h idle=%0b want 0 1", rd_pd, fifo_idle); end
    tick(); tick();
    rstn = 1'b1;
    tick();
    #2;
    n_tests++; if (wr_prdy !== 1'b1 || rd_pvld !== 1'b0) begin n_fail++; $display("FAIL mr_release: prdy=%0b pvld=%0b want 1 0", wr_prdy, rd_pvld); end
    wr_pvld = 1'b1; wr_pd = d; rd_prdy = 1'b1;
    #1;
    n_tests++; if (ram_we !== 1'b1 || ram_wa !== 6'd0) begin n_fail++; $display("FAIL mr_wa: we=%0b wa=%0d want 1 0", ram_we, ram_wa); end
    tick();
    wr_pvld = 1'b0;
    lat = 0;
    while (!rd_pvld && lat < 10) begin
      tick();
      lat++;
    end
    #1;
    n_tests++; if (rd_pvld !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL mr_pop_wait: pvld=%0b lat=%0d want 1 2", rd_pvld, lat); end
    n_tests++; if (rd_pd !== d) begin n_fail++; $display("FAIL mr_pop_data: got %h want %h", rd_pd, d); end
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      n_tests++; if (rd_pvld !== 1'b0 || rd_pd !== d) begin n_fail++; $display("FAIL mr_empty_c%0d: pvld=%0b pd=%h want 0 %h", i, rd_pvld, rd_pd, d); end
    end
    rd_prdy = 1'b0;
  endtask

  task automatic test_passthrough();
    pwrbus_ram_pd = 32'hDEADBEEF;
    #1;
    n_tests++; if (ram_pwrbus_pd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pwr_deadbeef: got %h want deadbeef", ram_pwrbus_pd); end
    pwrbus_ram_pd = 32'h12345678;
    #1;
    n_tests++; if (ram_pwrbus_pd !== 32'h12345678) begin n_fail++; $display("FAIL pwr_12345678: got %h want 12345678", ram_pwrbus_pd); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_backpressure();
    test_midreset();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_ram_rws_fifo_ctrl.md
Name: nv_ram_rws_fifo_ctrl

Overview:
- Valid/ready FIFO controller that drives an external 1R1W RAM (DEPTH x DW) with a registered read address.
- The RAM read data is combinational from the stored entry selected by the read address latched on the previous re.
- The controller owns the write and read pointers and issues RAM reads ahead of demand. It captures read data into a 2-entry output skid buffer and presents a registered pop interface.
- Sits between a producer and consumer in the core clock domain; it is the master/reader side of the rws RAM interface.

Parameters:
- DEPTH, 64, number of RAM entries; power of two, >=4.
- AW, 6, RAM address width; equals log2(DEPTH).
- DW, 512, data width.

Ports:
- nvdla_core_clk  input  1  core clock.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- wr_pvld  input  1  push valid.
- wr_prdy  output  1  push ready.
- wr_pd  input  DW  push data.
- rd_pvld  output  1  pop valid.
- rd_prdy  input  1  pop ready.
- rd_pd  output  DW  pop data, from the skid head register.
- ram_wa  output  AW  RAM write address.
- ram_we  output  1  RAM write enable.
- ram_di  output  DW  RAM write data; equals wr_pd.
- ram_ra  output  AW  RAM read address.
- ram_re  output  1  RAM read enable.
- ram_dout  input  DW  RAM read data; valid the cycle after ram_re.
- pwrbus_ram_pd  input  32  RAM power control; forwarded unchanged.
- ram_pwrbus_pd  output  32  passthrough of pwrbus_ram_pd.
- fifo_idle  output  1  high when no entries are held anywhere.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, ram_cnt=0, inflight=0, skid_cnt=0. Reset output values:
  - wr_prdy=0 during reset, then 1 from the first cycle after release.
  - rd_pvld=0, ram_re=0, ram_we=0, fifo_idle=1.
  - rd_pd holds X-safe 0.
- Push: accepted when wr_pvld & wr_prdy. In the same cycle ram_we=1 and ram_wa=wr_ptr. wr_ptr increments mod DEPTH.
- wr_prdy = (ram_cnt < DEPTH), registered.
  - ram_cnt counts entries written but not yet captured into the skid, including the in-flight read.
  - A slot is freed only at capture, never at read issue, so a RAM slot is never overwritten while its read is pending.
- Read issue: ram_re=1 and ram_ra=rd_ptr when (ram_cnt - inflight) > 0 and (skid_cnt + inflight) < 2, with the skid slot-release term described below. rd_ptr increments mod DEPTH on issue; inflight<=1 next cycle.
- Capture: the cycle after issue (inflight=1), ram_dout is written into the skid tail at the clock edge, and ram_cnt decrements.
- Skid buffer: 2 entries. rd_pvld = (skid_cnt > 0). A pop (rd_pvld & rd_prdy) removes the head.
- Slot-release term: pop and capture may occur in the same cycle. Read issue uses the registered skid_cnt, plus the combinational pop of the current cycle as a slot release, so full throughput is 1 entry/cycle.
- Latency: a push accepted at edge E0 gives ram_re high after E0, capture at E2, and rd_pvld high after E2. Empty-to-pop latency is 3 cycles.
- Counter update on simultaneous events: push, capture, and pop in the same cycle update the counters independently. ram_cnt += push - capture; skid_cnt += capture - pop.
- Total capacity: DEPTH + 2 entries.
- Full: wr_prdy=0 when ram_cnt==DEPTH. A wr_pvld held high stalls with wr_pd held; no write is issued.
- Empty: rd_pvld=0 and rd_pd is stable; no ram_re is issued.
- Pointer wrap: wr_ptr and rd_ptr are AW bits and wrap silently. Full and empty are determined from counters, never from pointer compare.
- rd_pd must not change while rd_pvld=1 and rd_prdy=0.
- Reset mid-operation: all contents are discarded and pointers return to 0. Any inflight read result is ignored after release.
- fifo_idle = (ram_cnt==0) & (skid_cnt==0) & ~wr_pvld.
- Assertions: ram_cnt <= DEPTH; skid_cnt+inflight <= 2; no ram_we to the address of an uncaptured entry.

Decomposition:
- Shared package nv_fifo_pkg: constant for the skid depth (2); a function to compute AW from DEPTH.
- One sub-module: nv_fifo_skid2, a 2-entry DW-wide skid buffer with capture-in and valid/ready-out. The top-level holds the pointers, counters, and RAM port drive.

Test Plan:
- Single entry: reset, push 0xA5 (replicated) once, rd_prdy=1 → ram_we cycle 0 at wa=0; ram_re cycle 1 at ra=0; rd_pvld cycle 3 with rd_pd=0xA5..; fifo_idle returns to 1.
- Fill: rd_prdy=0, push 70 entries with data=i → 66 accepted (64 RAM + 2 skid), then wr_prdy=0. Raise rd_prdy → data 0..65 popped in order, with wr_prdy reasserting after the first capture frees a slot.
- Streaming: push and pop every cycle for 200 entries → after initial latency, one pop per cycle, no bubbles; pointers wrap past 63→0 with data intact.
- Backpressure: random rd_prdy at 30%, random wr_pvld at 70%, 1000 entries → scoreboard order and data match; rd_pd stable while stalled.
- Mid-operation reset: with 10 entries queued and one read inflight, assert nvdla_core_rstn low → rd_pvld=0, wr_prdy=0, ram_re=0 immediately. After release, push 0x3C → it pops first, with no stale data.
- Passthrough: drive pwrbus_ram_pd=0xDEADBEEF → ram_pwrbus_pd=0xDEADBEEF in the same cycle.
